// File: rtl/ultrasonic_scheduler.sv
// Round-robin ultrasonic rangefinder scheduler: fires one sensor at a time, times its echo,
// reports each measurement and keeps a per-sensor proximity (crash) flag.
module ultrasonic_scheduler #(
  parameter int NUM_SENSORS   = 4,
  parameter int ID_W          = 2,
  parameter int TRIG_CYCLES   = 500,
  parameter int ECHO_TIMEOUT  = 1500000,
  parameter int SETTLE_CYCLES = 250000,
  parameter int CNT_W         = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NUM_SENSORS-1:0] enable_mask,
  input  logic [CNT_W-1:0]       thresh,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic                   meas_valid,
  output logic [ID_W-1:0]        meas_id,
  output logic [CNT_W-1:0]       meas_width,
  output logic                   meas_timeout,
  output logic [NUM_SENSORS-1:0] crash,
  output logic                   crash_any,
  output logic [2:0]             dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_SETTLE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_W   = CNT_W'(ECHO_TIMEOUT);
  // SETTLE holds one completion cycle plus SETTLE_CYCLES dead cycles.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [NUM_SENSORS-1:0] ONE_HOT_BASE = NUM_SENSORS'(1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       width_q, width_d;
  logic [ID_W-1:0]        sel_q, sel_d;
  logic [ID_W-1:0]        last_id_q;
  logic [NUM_SENSORS-1:0] echo_m_q, echo_s_q;
  logic                   meas_valid_q;
  logic [ID_W-1:0]        meas_id_q;
  logic [CNT_W-1:0]       meas_width_q;
  logic                   meas_timeout_q;
  logic [NUM_SENSORS-1:0] crash_q, crash_d;

  logic                   done;
  logic                   done_timeout;
  logic [CNT_W-1:0]       done_width;
  logic                   hit;
  logic [NUM_SENSORS-1:0] sel_onehot;
  logic                   echo_sel;
  logic [ID_W-1:0]        next_id;

  // First enabled index strictly after last, wrapping modulo NUM_SENSORS.
  function automatic logic [ID_W-1:0] next_enabled(input logic [ID_W-1:0]        last,
                                                   input logic [NUM_SENSORS-1:0] mask);
    logic [ID_W-1:0]        pick;
    logic                   found;
    logic [NUM_SENSORS-1:0] rot;
    int                     idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_SENSORS; i++) begin
      idx = (int'(last) + i) % NUM_SENSORS;
      rot = mask >> idx;
      if (!found && rot[0]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign sel_onehot = ONE_HOT_BASE << sel_q;
  assign echo_sel   = |(echo_s_q & sel_onehot);
  assign next_id    = next_enabled(last_id_q, enable_mask);

  // Two-flop synchronizer per raw echo line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_m_q <= '0;
      echo_s_q <= '0;
    end else begin
      echo_m_q <= echo;
      echo_s_q <= echo_m_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      width_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic; done marks the cycle whose result is registered at the next edge.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    width_d      = width_q;
    done         = 1'b0;
    done_timeout = 1'b0;
    done_width   = '0;
    case (state_q)
      S_IDLE: begin
        if (en && (|enable_mask)) begin
          sel_d   = next_id;
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        if (cnt_q == TRIG_LAST) state_d = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (echo_sel) begin
          width_d = CNT_W'(1);
          state_d = S_MEASURE;
        end else if (cnt_q == WAIT_LAST) begin
          done         = 1'b1;
          done_timeout = 1'b1;
          state_d      = S_SETTLE;
        end
      end
      S_MEASURE: begin
        if (echo_sel) begin
          width_d = width_q + 1'b1;
          if (width_d == TIMEOUT_W) begin
            done         = 1'b1;
            done_timeout = 1'b1;
            done_width   = TIMEOUT_W;
            state_d      = S_SETTLE;
          end
        end else begin
          done       = 1'b1;
          done_width = width_q;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : cnt_q + 1'b1;
  end

  assign hit = !done_timeout && (done_width < thresh);

  always_comb begin
    crash_d = crash_q;
    if (done) crash_d = (crash_q & ~sel_onehot) | (hit ? sel_onehot : '0);
  end

  // meas_valid is a one-cycle strobe with no back-pressure: meas_* are valid while it is high
  // and hold their value until the next strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_valid_q   <= 1'b0;
      meas_id_q      <= '0;
      meas_width_q   <= '0;
      meas_timeout_q <= 1'b0;
      last_id_q      <= ID_W'(NUM_SENSORS - 1);
      crash_q        <= '0;
    end else begin
      meas_valid_q <= done;
      crash_q      <= crash_d;
      if (done) begin
        meas_id_q      <= sel_q;
        meas_width_q   <= done_width;
        meas_timeout_q <= done_timeout;
        last_id_q      <= sel_q;
      end
    end
  end

  // Output logic: trig decodes registered state, so async reset clears it at once.
  always_comb begin
    trig         = (state_q == S_TRIG) ? sel_onehot : '0;
    meas_valid   = meas_valid_q;
    meas_id      = meas_id_q;
    meas_width   = meas_width_q;
    meas_timeout = meas_timeout_q;
    crash        = crash_q;
    crash_any    = |crash_q;
    dbg_state_o  = state_q;
  end

endmodule
